// File: rtl/menshen_pkg.sv
// Shared constants for the Menshen egress path: default PHV width and the
// location and width of the output-queue field inside a PHV.
package menshen_pkg;

    localparam int PHV_LEN_DEF = 1024;  // 48*8 + 32*8 + 16*8 + 256
    localparam int QBIT_LSB    = 141;   // LSB of the destination queue field
    localparam int QBIT_W      = 4;     // queue field width, one-hot
    localparam int STAT_W      = 32;    // statistics counter width

endpackage : menshen_pkg

// File: rtl/phv_egress_fifo_if.sv
// Bundle of the PHV egress FIFO handshake, data and status signals.
// Optional statistics signals exist only when PHV_FIFO_STATS_EN is defined.
interface phv_egress_fifo_if
    import menshen_pkg::*;
#(
    parameter int PHV_LEN = PHV_LEN_DEF,
    parameter int ADDR_W  = 4
) ();

    logic [PHV_LEN-1:0] phv_in;
    logic               phv_in_valid;
    logic               phv_fifo_ready;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_out_valid;
    logic               phv_out_ready;
    logic [QBIT_W-1:0]  phv_out_qmask;
    logic [ADDR_W:0]    fifo_count;
    logic               overflow;
`ifdef PHV_FIFO_STATS_EN
    logic [STAT_W-1:0]  stat_drop_cnt;
    logic [ADDR_W:0]    stat_hwm;
`endif

    // Upstream stage / downstream deparser / status observer side.
    modport master (
        output phv_in, phv_in_valid, phv_out_ready,
        input  phv_fifo_ready, phv_out, phv_out_valid, phv_out_qmask,
               fifo_count, overflow
`ifdef PHV_FIFO_STATS_EN
        , input stat_drop_cnt, stat_hwm
`endif
    );

    // FIFO side.
    modport slave (
        input  phv_in, phv_in_valid, phv_out_ready,
        output phv_fifo_ready, phv_out, phv_out_valid, phv_out_qmask,
               fifo_count, overflow
`ifdef PHV_FIFO_STATS_EN
        , output stat_drop_cnt, stat_hwm
`endif
    );

endinterface : phv_egress_fifo_if

// File: rtl/phv_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A write to the address being read forwards the write data into the read
// register, so a word written into an empty FIFO is visible one cycle later.
module phv_fifo_ram #(
    parameter int DATA_W = 1024,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Storage array write.
    // NOTE: the array is deliberately not reset; a reset here would turn the RAM into flops.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read with write-first forwarding on an address collision.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : phv_fifo_ram

// File: rtl/phv_egress_fifo.sv
// PHV egress FIFO between the last pipeline stage and the deparser.
// First-word-fall-through output, early ready with AF_MARGIN free entries of
// slack for the upstream output register, occupancy and sticky overflow.
// Define PHV_FIFO_STATS_EN to add a saturating drop counter and a high-water mark.
module phv_egress_fifo
    import menshen_pkg::*;
#(
    parameter int PHV_LEN   = PHV_LEN_DEF,
    parameter int ADDR_W    = 4,
    parameter int AF_MARGIN = 3
) (
    input  logic              axis_clk,
    input  logic              aresetn,
    phv_egress_fifo_if.slave  bus
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] RDY_LIM  = (ADDR_W+1)'(DEPTH - AF_MARGIN);

    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               valid_q;
    logic               ready_q;
    logic               overflow_q;
    logic               full, push, pop, drop;
    logic [PHV_LEN-1:0] ram_rdata;

    // Handshake decode and next-state for pointers and occupancy.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        full     = (count_q == FULL_CNT);
        pop      = valid_q & bus.phv_out_ready;
        push     = bus.phv_in_valid & (~full | pop);
        drop     = bus.phv_in_valid & full & ~pop;
        wr_ptr_d = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end
    end

    // Pointer, occupancy, output-valid, early-ready and sticky overflow registers.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= (count_d != '0);
            ready_q    <= (count_d < RDY_LIM);
            overflow_q <= overflow_q | drop;
        end
    end

    // Read address runs one step ahead so the read register holds the next head.
    phv_fifo_ram #(
        .DATA_W (PHV_LEN),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (axis_clk),
        .rst_n   (aresetn),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.phv_in),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_rdata)
    );

    assign bus.phv_out        = ram_rdata;
    assign bus.phv_out_qmask  = ram_rdata[QBIT_LSB +: QBIT_W];
    assign bus.phv_out_valid  = valid_q;
    assign bus.phv_fifo_ready = ready_q;
    assign bus.fifo_count     = count_q;
    assign bus.overflow       = overflow_q;

`ifdef PHV_FIFO_STATS_EN
    logic [STAT_W-1:0] drop_cnt_q;
    logic [ADDR_W:0]   hwm_q;

    // Saturating drop counter and occupancy high-water mark.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            drop_cnt_q <= '0;
            hwm_q      <= '0;
        end else begin
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + STAT_W'(1);
            end
            if (count_d > hwm_q) begin
                hwm_q <= count_d;
            end
        end
    end

    assign bus.stat_drop_cnt = drop_cnt_q;
    assign bus.stat_hwm      = hwm_q;
`endif

endmodule : phv_egress_fifo
